// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers (EX stage).
// Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring), one iteration per
// cycle, plus MTHI/MTLO writes. HI/LO feed the EX result mux directly.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      launch operation (sampled only while idle)
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b       rs / rt operands
//   mthi/mtlo  write a into HI / LO while idle and not starting
//   busy       operation in progress
//   done       one-cycle pulse, HI/LO hold the new result
//   hi, lo     architectural HI/LO registers
module mul_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;   // negate product / quotient
  logic             neg_rem_q, neg_rem_d;   // negate remainder (dividend sign)
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;         // multiplicand or divisor magnitude
  logic [WIDTH-1:0] a_raw_q, a_raw_d;       // dividend as presented, for divide-by-zero
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;     // product high / partial remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;     // multiplier bits / dividend-then-quotient
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand magnitudes; unsigned ops pass through unchanged.
  logic             op_signed;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign op_signed = ~op[0];
  assign abs_a     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (op_signed && b[WIDTH-1]) ? -b : b;

  // Shift-add step: conditionally add multiplicand to the upper half, then
  // shift the whole accumulator right with the carry entering at the top.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

  // Restoring-divide step: shift in the next dividend bit and trial-subtract.
  logic [WIDTH:0] div_shift, div_diff;
  logic           div_ge;
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = ~div_diff[WIDTH];

  // Sign correction applied in FIX.
  logic [PW-1:0]    prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign quo_fix  = neg_res_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      opnd_q     <= opnd_d;
      a_raw_q    <= a_raw_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    opnd_d     = opnd_q;
    a_raw_d    = a_raw_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d    = CALC;
          busy_d     = 1'b1;
          cnt_d      = '0;
          is_div_d   = op[1];
          neg_res_d  = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d  = op_signed & op[1] & a[WIDTH-1];
          div_zero_d = op[1] & (b == '0);
          a_raw_d    = a;
          opnd_d     = op[1] ? abs_b : abs_a;
          acc_hi_d   = '0;
          acc_lo_d   = op[1] ? abs_a : abs_b;
        end else begin
          // start has priority over MT writes
          if (mthi) hi_d = a;
          if (mtlo) lo_d = a;
        end
      end

      CALC: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          acc_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end

      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[PW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div_zero_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
